// File: rtl/match_event_counter_if.sv
// match_event_counter_if
// Groups the match flag, soft clear and all count/status results of
// match_event_counter into one bundle.
//   ans_in    : match flag from the sequence detector (level)
//   clr       : synchronous soft clear of the counters
//   cnt_total : saturating lifetime count of match events
//   sat       : sticky flag, cnt_total has reached its maximum
//   cnt_win   : event count of the most recently completed window
//   win_done  : one-cycle pulse when cnt_win is updated
//   last_gap  : cycles between the two most recent events (saturating)
// master drives ans_in/clr and observes results; slave is the counter.
interface match_event_counter_if #(
    parameter int CNT_W = 8
) ();
    logic             ans_in;
    logic             clr;
    logic [CNT_W-1:0] cnt_total;
    logic             sat;
    logic [CNT_W-1:0] cnt_win;
    logic             win_done;
    logic [CNT_W-1:0] last_gap;

    modport master (
        output ans_in, clr,
        input  cnt_total, sat, cnt_win, win_done, last_gap
    );

    modport slave (
        input  ans_in, clr,
        output cnt_total, sat, cnt_win, win_done, last_gap
    );
endinterface

// File: rtl/match_event_counter.sv
// match_event_counter
// Counts rising edges of the detector's match flag. Keeps a saturating
// lifetime total with a sticky saturation flag, a per-window event count
// latched every WIN_LEN cycles, and the gap in cycles between the two most
// recent events. All outputs are registered.
//   clk   : system clock, all state changes on posedge
//   reset : synchronous, active-high reset (priority over clr)
//   bus   : match_event_counter_if.slave (ans_in, clr in; counts out)
module match_event_counter #(
    parameter int CNT_W   = 8,
    parameter int WIN_LEN = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    match_event_counter_if.slave   bus
);
    localparam logic [CNT_W-1:0] MAX      = '1;
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(WIN_LEN - 1);

    typedef enum logic {S_LOW, S_HIGH} state_t;

    state_t           state;
    logic             edge_det;
    logic [CNT_W-1:0] timer;
    logic [CNT_W-1:0] acc;
    logic [CNT_W-1:0] gap_cnt;
    logic [CNT_W-1:0] total_q;
    logic             sat_q;
    logic [CNT_W-1:0] win_q;
    logic             done_q;
    logic [CNT_W-1:0] gap_q;

    // Edge is internal only; it is consumed by the registers below on the
    // same posedge, so no output depends combinationally on ans_in.
    always_comb begin
        edge_det = (state == S_LOW) && bus.ans_in;
    end

    // Tracker state keeps following ans_in through clr so that a flag held
    // high across a clear is not counted a second time.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_LOW;
        end else begin
            state <= bus.ans_in ? S_HIGH : S_LOW;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || bus.clr) begin
            timer   <= '0;
            acc     <= '0;
            gap_cnt <= '0;
            total_q <= '0;
            sat_q   <= 1'b0;
            win_q   <= '0;
            done_q  <= 1'b0;
            gap_q   <= '0;
        end else begin
            if (edge_det && total_q != MAX) begin
                total_q <= total_q + ONE;
            end
            // Sticky: set on the edge that brings the total to MAX.
            if (edge_det && total_q == MAX - ONE) begin
                sat_q <= 1'b1;
            end

            if (edge_det) begin
                gap_q   <= (gap_cnt == MAX) ? MAX : gap_cnt + ONE;
                gap_cnt <= '0;
            end else if (gap_cnt != MAX) begin
                gap_cnt <= gap_cnt + ONE;
            end

            // An edge in the last window cycle closes into this window.
            if (timer == WIN_LAST) begin
                win_q  <= (edge_det && acc != MAX) ? acc + ONE : acc;
                acc    <= '0;
                timer  <= '0;
                done_q <= 1'b1;
            end else begin
                timer  <= timer + ONE;
                done_q <= 1'b0;
                if (edge_det && acc != MAX) begin
                    acc <= acc + ONE;
                end
            end
        end
    end

    assign bus.cnt_total = total_q;
    assign bus.sat       = sat_q;
    assign bus.cnt_win   = win_q;
    assign bus.win_done  = done_q;
    assign bus.last_gap  = gap_q;
endmodule

// File: doc/match_event_counter.md
Name: match_event_counter

Overview:
- Downstream consumer of the sequence detector's 1-bit `ans` match flag.
- Counts match events, meaning rising edges of the flag, so a flag held high for many cycles counts once.
- Maintains a saturating lifetime total, a per-window count latched every WIN_LEN cycles, and the cycle gap since the last match.
- Results feed the status/display logic.

Parameters:
- CNT_W, default 8: width of all counters and count outputs.
- WIN_LEN, default 16: window length in clock cycles. Legal range 2..2^CNT_W-1.

Ports:
- clk, input, 1: system clock. All state changes on posedge.
- reset, input, 1: synchronous, active-high reset.
- ans_in, input, 1: match flag from the detector. Level signal; may stay high for several cycles.
- clr, input, 1: synchronous soft clear of the counters.
- cnt_total, output, CNT_W: saturating count of match events since reset/clr.
- sat, output, 1: sticky flag; set when cnt_total reaches 2^CNT_W-1.
- cnt_win, output, CNT_W: event count of the most recently completed window.
- win_done, output, 1: one-cycle pulse when cnt_win is updated.
- last_gap, output, CNT_W: cycles between the two most recent events, saturating.

Behaviour:

Reset:
- Input tracker goes to S_LOW.
- cnt_total=0, sat=0, cnt_win=0, win_done=0, last_gap=0.
- Window timer=0, window accumulator=0, gap counter=0.

Input tracker FSM (two states):
- S_LOW: ans_in=1 -> S_HIGH and assert internal edge for this cycle; ans_in=0 -> stay.
- S_HIGH: ans_in=0 -> S_LOW; ans_in=1 -> stay, no edge.
- ans_in already high when reset deasserts: counts as one edge on the first cycle out of reset.

Latency and counting:
- Edge sampled at posedge N: cnt_total and the accumulator show the increment after posedge N (one-cycle latency). No combinational path from ans_in to any output.

Saturation:
- cnt_total at 2^CNT_W-1 holds its value; sat=1 from the cycle cnt_total first equals the max.
- The accumulator saturates at 2^CNT_W-1. No wrap-around anywhere.

Window:
- Timer counts 0..WIN_LEN-1 every cycle.
- On the cycle timer==WIN_LEN-1: cnt_win <= accumulator + edge (saturating), accumulator <= 0, timer <= 0, win_done=1 for that cycle only.
- An edge in the final window cycle belongs to the closing window, not the next one.

Gap:
- Gap counter increments every cycle and saturates at 2^CNT_W-1.
- On an edge: last_gap <= gap counter + 1 (saturating), gap counter <= 0.
- The first edge after reset/clr loads the cycles elapsed since reset/clr.

clr:
- Same effect as reset on cnt_total, sat, cnt_win, accumulator, timer, gap counter and last_gap. win_done=0.
- The FSM state is NOT cleared, so a flag held high across clr is not recounted.
- An edge coinciding with clr is discarded. reset has priority over clr.

Test Plan:
- Reset, hold ans_in=0 for 40 cycles -> all outputs 0; win_done pulses at cycles 16 and 32 with cnt_win=0.
- After reset, ans_in high for 5 cycles, low 3, high 1 -> cnt_total=2; last_gap=8; sat=0.
- WIN_LEN=16: edges at timer values 3, 9, 15 -> at timer 15 win_done=1, cnt_win=3; next window's accumulator starts at 0.
- CNT_W=4: 20 single-cycle pulses separated by one low cycle -> cnt_total stops at 15; sat=1 from the 15th event on; no wrap to 0.
- ans_in held high, clr asserted mid-high, ans_in stays high 4 more cycles -> cnt_total=0 after clr and remains 0; sat/last_gap cleared.
- Edge on the same cycle as clr -> cnt_total=0 afterwards; reset and clr asserted together -> FSM returns to S_LOW.
